// File: rtl/mem_pkg.sv
// mem_pkg: constants and the round-robin helper shared by mem_rr_arbiter and rr_arbiter.
//   MEM_DATA_W / MEM_ADDR_W : default word and address widths
//   rr_result_t             : one-hot grant, binary index and any-grant flag
//   rr_next()               : next round-robin winner after 'last' among the first n requesters
package mem_pkg;

    localparam int unsigned MEM_DATA_W = 16;
    localparam int unsigned MEM_ADDR_W = 8;

    // The helper works on a fixed 8-wide vector; callers zero-extend narrower request sets.
    localparam int unsigned RR_MAX_N = 8;
    localparam int unsigned RR_IDX_W = 3;

    typedef struct packed {
        logic                valid;
        logic [RR_IDX_W-1:0] idx;
        logic [RR_MAX_N-1:0] grant;
    } rr_result_t;

    // Scan the channels that follow 'last', in ascending order with wrap-around. The first
    // requester found wins. n is a constant at each call site, so the modulo folds away.
    function automatic rr_result_t rr_next(input logic [RR_MAX_N-1:0] req,
                                           input logic [RR_IDX_W-1:0] last,
                                           input int unsigned         n);
        rr_result_t          res;
        logic [RR_IDX_W-1:0] cand;
        res = '0;
        for (int unsigned k = 1; k <= RR_MAX_N; k++) begin
            cand = RR_IDX_W'((32'(last) + k) % n);
            if (k <= n && !res.valid && req[cand]) begin
                res.valid       = 1'b1;
                res.idx         = cand;
                res.grant[cand] = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter for N requesters (1..8).
//   i_clk, i_nRst  : clock, asynchronous active-low reset
//   i_req          : request vector
//   i_advance      : the current grant was accepted; move last_grant to it
//   o_grant        : one-hot grant (combinational)
//   o_grant_idx    : binary index of o_grant
module rr_arbiter
    import mem_pkg::*;
#(
    parameter  int unsigned N    = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            i_clk,
    input  logic            i_nRst,
    input  logic [N-1:0]    i_req,
    input  logic            i_advance,
    output logic [N-1:0]    o_grant,
    output logic [IdxW-1:0] o_grant_idx
);

    logic [IdxW-1:0] r_last_grant;
    rr_result_t      w_res;
    logic            w_unused;

    always_comb begin
        w_res = rr_next(RR_MAX_N'(i_req), RR_IDX_W'(r_last_grant), N);
    end

    assign o_grant     = w_res.grant[N-1:0];
    assign o_grant_idx = w_res.idx[IdxW-1:0];
    assign w_unused    = ^w_res;

    // Reset to N-1 so that channel 0 is first in line.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_last_grant <= IdxW'(N - 1);
        end else if (i_advance) begin
            r_last_grant <= o_grant_idx;
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: simple dual-port RAM shared by CHANNELS clients. Writes and reads have
// separate round-robin arbiters. Read data returns two cycles after acceptance on a shared
// bus, tagged by a one-hot valid.
//   i_clk, i_nRst             : clock, asynchronous active-low reset
//   i_wr_req/addr/data        : per-channel write request (held until o_wr_ack)
//   o_wr_ack                  : one-hot write accept (combinational)
//   i_rd_req/addr             : per-channel read request (held until o_rd_ack)
//   o_rd_ack                  : one-hot read accept (combinational)
//   o_rd_valid, o_rd_data     : registered one-hot owner tag and shared read data
module mem_rr_arbiter
    import mem_pkg::*;
#(
    parameter  int unsigned DATA_W   = MEM_DATA_W,
    parameter  int unsigned ADDR_W   = MEM_ADDR_W,
    parameter  int unsigned CHANNELS = 2,
    localparam int unsigned IdxW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_nRst,
    input  logic [CHANNELS-1:0]        i_wr_req,
    input  logic [CHANNELS*ADDR_W-1:0] i_wr_addr,
    input  logic [CHANNELS*DATA_W-1:0] i_wr_data,
    output logic [CHANNELS-1:0]        o_wr_ack,
    input  logic [CHANNELS-1:0]        i_rd_req,
    input  logic [CHANNELS*ADDR_W-1:0] i_rd_addr,
    output logic [CHANNELS-1:0]        o_rd_ack,
    output logic [CHANNELS-1:0]        o_rd_valid,
    output logic [DATA_W-1:0]          o_rd_data
);

    logic [CHANNELS-1:0] w_wr_grant;
    logic [CHANNELS-1:0] w_rd_grant;
    logic [CHANNELS-1:0] w_wr_ack;
    logic [CHANNELS-1:0] w_rd_ack;
    logic [IdxW-1:0]     w_wr_idx_unused;
    logic [IdxW-1:0]     w_rd_idx_unused;

    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic [ADDR_W-1:0]   w_rd_addr;

    logic [DATA_W-1:0]   r_mem [2**ADDR_W];
    logic [DATA_W-1:0]   r_ram_q;
    logic [CHANNELS-1:0] r_tag_s1;
    logic [CHANNELS-1:0] r_tag_s2;
    logic [DATA_W-1:0]   r_rd_data;

    rr_arbiter #(
        .N (CHANNELS)
    ) u_wr_arb (
        .i_clk       (i_clk),
        .i_nRst      (i_nRst),
        .i_req       (i_wr_req),
        .i_advance   (|w_wr_ack),
        .o_grant     (w_wr_grant),
        .o_grant_idx (w_wr_idx_unused)
    );

    rr_arbiter #(
        .N (CHANNELS)
    ) u_rd_arb (
        .i_clk       (i_clk),
        .i_nRst      (i_nRst),
        .i_req       (i_rd_req),
        .i_advance   (|w_rd_ack),
        .o_grant     (w_rd_grant),
        .o_grant_idx (w_rd_idx_unused)
    );

    // Nothing is accepted while reset is held, even though the arbiter is combinational.
    assign w_wr_ack = w_wr_grant & {CHANNELS{i_nRst}};
    assign w_rd_ack = w_rd_grant & {CHANNELS{i_nRst}};
    assign o_wr_ack = w_wr_ack;
    assign o_rd_ack = w_rd_ack;

    // AND-OR mux over the one-hot acks.
    always_comb begin
        w_wr_en   = |w_wr_ack;
        w_wr_addr = '0;
        w_wr_data = '0;
        w_rd_addr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_wr_ack[c]) begin
                w_wr_addr = w_wr_addr | i_wr_addr[c*ADDR_W +: ADDR_W];
                w_wr_data = w_wr_data | i_wr_data[c*DATA_W +: DATA_W];
            end
            if (w_rd_ack[c]) begin
                w_rd_addr = w_rd_addr | i_rd_addr[c*ADDR_W +: ADDR_W];
            end
        end
    end

    // RAM read samples the accepted address at the acceptance edge (the block RAM's internal
    // address register). Both ports update on the same edge, so a same-address write in that
    // cycle is not yet visible: old data is returned.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
        r_ram_q <= r_mem[w_rd_addr];
    end

    // Tag pipeline runs alongside the RAM. The output register loads only for a real read,
    // so o_rd_data holds between results.
    always_ff @(posedge i_clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_tag_s1  <= '0;
            r_tag_s2  <= '0;
            r_rd_data <= '0;
        end else begin
            r_tag_s1 <= w_rd_ack;
            r_tag_s2 <= r_tag_s1;
            if (|r_tag_s1) begin
                r_rd_data <= r_ram_q;
            end
        end
    end

    assign o_rd_valid = r_tag_s2;
    assign o_rd_data  = r_rd_data;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
module tb_mem_rr_arbiter;

    localparam int NCH = 4;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wreq_t;

    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic [3:0]  wr_req, rd_req, wr_ack, rd_ack, rd_valid;
    logic [31:0] wr_addr, rd_addr;
    logic [63:0] wr_data;
    logic [15:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Stimulus queues per channel and the expected read-result scoreboard.
    wreq_t      wq[NCH][$];
    logic [7:0] rq[NCH][$];
    exp_t       expq[$];

    // Reference model state.
    logic [15:0] mm [256];
    int          m_last_w, m_last_r;
    logic [15:0] m_hold;
    logic [3:0]  acc_w, acc_r;
    int          ack_cnt[NCH];
    int          vld_cnt[NCH];

    mem_rr_arbiter #(
        .DATA_W   (16),
        .ADDR_W   (8),
        .CHANNELS (NCH)
    ) dut (
        .i_clk      (clk),
        .i_nRst     (nrst),
        .i_wr_req   (wr_req),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .o_wr_ack   (wr_ack),
        .i_rd_req   (rd_req),
        .i_rd_addr  (rd_addr),
        .o_rd_ack   (rd_ack),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [3:0] rr_ref(input logic [3:0] req, input int last);
        for (int k = 1; k <= NCH; k++) begin
            if (req[(last + k) % NCH]) return 4'(1 << ((last + k) % NCH));
        end
        return 4'b0;
    endfunction

    function automatic bit busy();
        for (int c = 0; c < NCH; c++) begin
            if (wq[c].size() != 0 || rq[c].size() != 0) return 1'b1;
        end
        return expq.size() != 0;
    endfunction

    task automatic push_wr(input int c, input logic [7:0] a, input logic [15:0] d);
        wreq_t w;
        w.addr = a;
        w.data = d;
        wq[c].push_back(w);
    endtask

    task automatic push_rd(input int c, input logic [7:0] a);
        rq[c].push_back(a);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy() && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check("drain_timeout", 32'(busy()), 32'd0);
    endtask

    // Monitor: mid-cycle, compare acks against the reference arbiter and rd_valid/rd_data
    // against the scoreboard, then advance the model.
    always @(negedge clk) begin : mon
        logic [3:0] gw, gr;
        int         iw, ir;
        exp_t       e;
        if (!nrst) begin
            check("rst_wr_ack", 32'(wr_ack), 32'd0);
            check("rst_rd_ack", 32'(rd_ack), 32'd0);
            check("rst_rd_valid", 32'(rd_valid), 32'd0);
            check("rst_rd_data", 32'(rd_data), 32'd0);
            m_last_w = NCH - 1;
            m_last_r = NCH - 1;
            m_hold   = 16'h0;
            expq.delete();
            acc_w = '0;
            acc_r = '0;
        end else begin
            gw = rr_ref(wr_req, m_last_w);
            gr = rr_ref(rd_req, m_last_r);
            check("wr_ack", 32'(wr_ack), 32'(gw));
            check("rd_ack", 32'(rd_ack), 32'(gr));
            for (int c = 0; c < NCH; c++) begin
                if (rd_ack[c]) ack_cnt[c]++;
                if (rd_valid[c]) vld_cnt[c]++;
            end
            if (expq.size() > 0 && expq[0].due == cyc) begin
                e = expq.pop_front();
                check("rd_valid", 32'(rd_valid), 32'(e.tag));
                check("rd_data", 32'(rd_data), 32'(e.data));
                m_hold = e.data;
            end else begin
                check("rd_valid_idle", 32'(rd_valid), 32'd0);
                check("rd_data_hold", 32'(rd_data), 32'(m_hold));
            end
            iw = 0;
            ir = 0;
            for (int c = 0; c < NCH; c++) begin
                if (gw[c]) iw = c;
                if (gr[c]) ir = c;
            end
            // Read before write: same-cycle collision returns old data.
            if (gr != 0) begin
                e.due  = cyc + 2;
                e.tag  = gr;
                e.data = mm[rd_addr[ir*8 +: 8]];
                expq.push_back(e);
                m_last_r = ir;
            end
            if (gw != 0) begin
                mm[wr_addr[iw*8 +: 8]] = wr_data[iw*16 +: 16];
                m_last_w = iw;
            end
            acc_w = gw;
            acc_r = gr;
        end
        cyc++;
    end

    // Driver: retire accepted heads, present the next head of each channel queue.
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (acc_w[c] && wq[c].size() > 0) wq[c].delete(0);
            if (acc_r[c] && rq[c].size() > 0) rq[c].delete(0);
            if (wq[c].size() > 0) begin
                wr_req[c]          = 1'b1;
                wr_addr[c*8 +: 8]  = wq[c][0].addr;
                wr_data[c*16 +: 16] = wq[c][0].data;
            end else begin
                wr_req[c] = 1'b0;
            end
            if (rq[c].size() > 0) begin
                rd_req[c]         = 1'b1;
                rd_addr[c*8 +: 8] = rq[c][0];
            end else begin
                rd_req[c] = 1'b0;
            end
        end
        acc_w = '0;
        acc_r = '0;
    end

    initial begin
        int n;
        nrst    = 1'b0;
        wr_req  = '0;
        rd_req  = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        for (int c = 0; c < NCH; c++) begin
            ack_cnt[c] = 0;
            vld_cnt[c] = 0;
        end
        repeat (3) @(posedge clk);
        #2 nrst = 1'b1;

        // Fairness: all four channels read continuously, three reads each.
        for (int c = 0; c < NCH; c++) push_wr(c, 8'(8'h40 + c), 16'(16'h4000 + c));
        drain();
        for (int c = 0; c < NCH; c++) begin
            ack_cnt[c] = 0;
            vld_cnt[c] = 0;
        end
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < NCH; c++) push_rd(c, 8'(8'h40 + c));
        end
        drain();
        for (int c = 0; c < NCH; c++) begin
            check("fair_acks", 32'(ack_cnt[c]), 32'd3);
            check("fair_valids", 32'(vld_cnt[c]), 32'd3);
        end

        // Single write then read.
        push_wr(0, 8'h02, 16'hABCD);
        drain();
        push_rd(0, 8'h02);
        drain();
        check("single_data", 32'(rd_data), 32'hABCD);

        // Write contention, then readback.
        push_wr(0, 8'h10, 16'h1111);
        push_wr(1, 8'h11, 16'h2222);
        drain();
        push_rd(0, 8'h10);
        drain();
        check("cont_rd0", 32'(rd_data), 32'h1111);
        push_rd(1, 8'h11);
        drain();
        check("cont_rd1", 32'(rd_data), 32'h2222);

        // Read-during-write to the same address, then a read one cycle later.
        push_wr(0, 8'h20, 16'h0001);
        drain();
        push_wr(1, 8'h20, 16'hBEEF);
        push_rd(0, 8'h20);
        push_rd(0, 8'h20);
        drain();
        check("rdw_second", 32'(rd_data), 32'hBEEF);

        // Boundary addresses.
        push_wr(2, 8'h00, 16'h5A5A);
        push_wr(3, 8'hFF, 16'hA5A5);
        drain();
        push_rd(0, 8'h00);
        drain();
        check("bound_lo", 32'(rd_data), 32'h5A5A);
        push_rd(1, 8'hFF);
        drain();
        check("bound_hi", 32'(rd_data), 32'hA5A5);

        // Reset in the cycle after a read is accepted.
        push_wr(0, 8'h30, 16'h1234);
        drain();
        for (int c = 0; c < NCH; c++) vld_cnt[c] = 0;
        push_rd(2, 8'h30);
        n = 0;
        while (rq[2].size() != 0 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check("rst_read_accept", 32'(rq[2].size()), 32'd0);
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #2 nrst = 1'b1;
        check("rst_after_data", 32'(rd_data), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        check("rst_no_valid", 32'(vld_cnt[2]), 32'd0);
        push_rd(1, 8'h30);
        push_rd(0, 8'h30);
        drain();
        check("rst_readback", 32'(rd_data), 32'h1234);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Parametrised multi-channel memory block: an inferred simple dual-port RAM shared by CHANNELS clients. Each client has independent write and read request ports. Writes and reads are arbitrated separately with round-robin fairness. Read data returns on a shared bus tagged by a one-hot valid at a fixed latency. It replaces single-client memory wrapping wherever several protocol engines (MIL-1553 RX/TX, SPI side) share one buffer RAM.

## Interface
- DATA_W, 16, word width
- ADDR_W, 8, address width; depth = 2**ADDR_W
- CHANNELS, 2, number of clients (1..8)
- clk  in  1  system clock, all logic on rising edge
- nRst  in  1  reset: asynchronous, active-low
- wr_req  in  CHANNELS  per-channel write request, held until acked
- wr_addr  in  CHANNELS×ADDR_W  per-channel write address
- wr_data  in  CHANNELS×DATA_W  per-channel write data
- wr_ack  out  CHANNELS  one-hot, combinational; high in the cycle the write is accepted
- rd_req  in  CHANNELS  per-channel read request, held until acked
- rd_addr  in  CHANNELS×ADDR_W  per-channel read address
- rd_ack  out  CHANNELS  one-hot, combinational; high in the cycle the read is accepted
- rd_valid  out  CHANNELS  one-hot, registered; marks the owner of rd_data
- rd_data  out  DATA_W  shared read data bus

## Operation
- Write and read ports are fully independent. Each can accept one request per cycle.
- Handshake: a client asserts req with stable addr/data. The request is accepted at the rising edge ending a cycle in which ack is high. The client may present a new request, or drop req, in the following cycle.
- Arbitration per port is round-robin. The grant goes to the first requesting channel after last_grant, in ascending order with wrap-around.
  - last_grant updates only on an accepted request.
  - Reset value of last_grant is CHANNELS-1, so channel 0 wins first.
- At most one ack bit is high per port. With no requests, ack = 0 and last_grant holds.
- Write: the accepted word is written to RAM at the acceptance edge.
- Read: the accepted address is registered into the RAM read stage. The RAM output is then registered together with the channel tag.
- Read-during-write to the same address in the same cycle returns OLD data.
- Reset values:
  - wr_ack = 0 and rd_ack = 0 (no requests pass while nRst = 0).
  - rd_valid = 0, rd_data = 0, last_grant = CHANNELS-1.
  - RAM contents are not cleared.
- Reset mid-operation: in-flight reads are discarded and no rd_valid is issued for them. Writes accepted before reset assertion remain in RAM.
- CHANNELS = 1 degenerates to ack = req.

## Timing
- Write latency: data is readable by a read accepted one cycle after the write's acceptance cycle or later.
- Read latency: accepted in cycle N, rd_valid/rd_data valid during cycle N+2, for exactly one cycle.
- Read throughput: 1 per cycle. Back-to-back reads from different channels produce back-to-back rd_valid, each with a different one-hot tag.
- Contention: with k channels continuously requesting, each is served exactly once every k cycles.
- rd_data holds its last value while rd_valid = 0.

## Structure
- Shared package mem_pkg:
  - default constants MEM_DATA_W = 16 and MEM_ADDR_W = 8
  - function rr_next(req, last) returning one-hot grant and index
- Sub-module rr_arbiter (parameter N):
  - inputs: clk, nRst, req, advance
  - outputs: grant (one-hot), grant_idx
  - owns the last_grant register
  - instantiated twice, once for writes and once for reads
- RAM is inferred in the top module: one write port, one registered read port, Quartus-inferable. Output register, tag pipeline and valid pipeline (2 stages) also live in the top module.

## Test plan
- Single write/read: ch0 writes 0xABCD at 0x02; ch0 reads 0x02 two cycles later. Required: wr_ack[0] one cycle, rd_valid = 2'b01 with rd_data = 0xABCD exactly two cycles after rd_ack.
- Write contention: ch0 and ch1 write simultaneously (0x10 = 0x1111, 0x11 = 0x2222) and hold req. Required: ch0 acked first, ch1 next cycle; readback returns both values.
- Round-robin fairness: CHANNELS = 4, all channels read continuously for 12 cycles. Required: rd_ack sequence 0,1,2,3 repeating; each channel gets 3 reads; rd_valid mirrors it two cycles later.
- Read-during-write: 0x20 preloaded 0x0001; in one cycle ch1 writes 0x20 = 0xBEEF and ch0 reads 0x20. Required: ch0 gets 0x0001; a read one cycle later gets 0xBEEF.
- Reset mid-read: read accepted, nRst asserted in the following cycle. Required: rd_valid never asserts, rd_data = 0, and ch0 wins first grant after release. A write made before reset reads back intact.
- Boundary addresses: writes to 0x00 and 0xFF with 0x5A5A/0xA5A5. Required: readback exact, no aliasing.
